// File: rtl/jtag_seq_pkg.sv
// Shared encodings for the JTAG TAP sequencer: command ops, FSM states and fixed TMS patterns.
// TMS patterns are stored LSB-first, i.e. bit 0 is driven on the first tick of the sequence.
package jtag_seq_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_IR    = 2'b01,
        OP_DR    = 2'b10,
        OP_IDLE  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRE_RST = 2'b01,
        ST_RUN     = 2'b10,
        ST_DONE    = 2'b11
    } st_e;

    localparam int RST_TICKS  = 6;
    localparam int IR_PRE_LEN = 4;
    localparam int DR_PRE_LEN = 3;
    localparam int SFX_LEN    = 2;

    localparam logic [5:0] TMS_RST    = 6'b011111;
    localparam logic [3:0] TMS_IR_PRE = 4'b0011;
    localparam logic [2:0] TMS_DR_PRE = 3'b001;
    localparam logic [1:0] TMS_SFX    = 2'b01;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: CLK_DIV cycles low then CLK_DIV cycles high while enabled, parked low otherwise.
// Strobes are asserted in the cycle before the HCLK edge on which TCK rises or falls.
// No backpressure; disabling mid-tick forces TCK low on the next edge.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic HCLK,
    input  logic HRESETN,
    input  logic i_en,
    output logic o_tck,
    output logic o_fall_stb,
    output logic o_rise_stb
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] r_phase;
    logic          r_tck;
    logic          w_wrap;

    assign w_wrap = i_en && (r_phase == PW'(CLK_DIV - 1));

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_phase <= '0;
            r_tck   <= 1'b0;
        end else if (!i_en) begin
            r_phase <= '0;
            r_tck   <= 1'b0;
        end else if (w_wrap) begin
            r_phase <= '0;
            r_tck   <= ~r_tck;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign o_tck      = r_tck;
    assign o_rise_stb = w_wrap & ~r_tck;
    assign o_fall_stb = w_wrap &  r_tck;

endmodule

// File: rtl/jtag_tap_sequencer.sv
// Fabric-side JTAG master: turns RESET/IR/DR/IDLE commands into TAP pin waveforms, returns TDO.
// rsp_valid pulses ticks*2*CLK_DIV+1 cycles after acceptance (+6 ticks if an initial TAP reset is inserted).
// cmd_ready only in IDLE; responses are single-cycle pulses with no backpressure.
module jtag_tap_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                           HCLK,
    input  logic                           HRESETN,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0]             cmd_tdi,
    output logic                           rsp_valid,
    output logic [MAX_LEN-1:0]             rsp_tdo,
    output logic                           rsp_err,
    output logic                           busy,
    output logic                           TCK,
    output logic                           TMS,
    output logic                           TDI,
    output logic                           TRSTB,
    input  logic                           TDO
);
    import jtag_seq_pkg::*;

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(MAX_LEN + 7);

    st_e               r_state, w_next;
    op_e               r_op, w_cmd_op;
    logic [LW-1:0]     r_len, w_rsh;
    logic [TW-1:0]     r_tick, r_total, w_cmd_total, w_tick_inc;
    logic              r_err, r_synced, r_tms, r_tdi, r_trstb, r_rsp_err;
    logic [MAX_LEN-1:0] r_sr, r_cap, r_rsp_tdo;
    logic              w_bad, w_tck_en, w_fall, w_rise;

    function automatic logic tms_for(input op_e op, input logic [TW-1:0] idx, input logic [LW-1:0] len);
        logic [TW-1:0] l;
        logic [TW-1:0] w;
        logic          t;
        l = TW'(len);
        w = '0;
        t = 1'b0;
        case (op)
            OP_RESET: t = (idx < TW'(RST_TICKS)) ? TMS_RST[idx[2:0]] : 1'b0;
            OP_IR: begin
                if (idx < TW'(IR_PRE_LEN)) begin
                    t = TMS_IR_PRE[idx[1:0]];
                end else if (idx < l + TW'(IR_PRE_LEN)) begin
                    t = (idx == l + TW'(IR_PRE_LEN - 1));
                end else begin
                    w = idx - l - TW'(IR_PRE_LEN);
                    t = TMS_SFX[w[0]];
                end
            end
            OP_DR: begin
                if (idx < TW'(DR_PRE_LEN)) begin
                    t = TMS_DR_PRE[idx[1:0]];
                end else if (idx < l + TW'(DR_PRE_LEN)) begin
                    t = (idx == l + TW'(DR_PRE_LEN - 1));
                end else begin
                    w = idx - l - TW'(DR_PRE_LEN);
                    t = TMS_SFX[w[0]];
                end
            end
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic shift_for(input op_e op, input logic [TW-1:0] idx, input logic [LW-1:0] len);
        logic s;
        s = 1'b0;
        case (op)
            OP_IR:   s = (idx >= TW'(IR_PRE_LEN)) && (idx < TW'(len) + TW'(IR_PRE_LEN));
            OP_DR:   s = (idx >= TW'(DR_PRE_LEN)) && (idx < TW'(len) + TW'(DR_PRE_LEN));
            default: s = 1'b0;
        endcase
        return s;
    endfunction

    assign w_cmd_op   = op_e'(cmd_op);
    assign w_bad      = (w_cmd_op != OP_RESET) && ((cmd_len == '0) || (cmd_len > LW'(MAX_LEN)));
    assign w_tick_inc = r_tick + TW'(1);
    assign w_rsh      = LW'(MAX_LEN) - r_len;

    always_comb begin
        w_cmd_total = '0;
        if (!w_bad) begin
            case (w_cmd_op)
                OP_RESET: w_cmd_total = TW'(RST_TICKS);
                OP_IR:    w_cmd_total = TW'(cmd_len) + TW'(IR_PRE_LEN + SFX_LEN);
                OP_DR:    w_cmd_total = TW'(cmd_len) + TW'(DR_PRE_LEN + SFX_LEN);
                default:  w_cmd_total = TW'(cmd_len);
            endcase
        end
    end

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .HCLK       (HCLK),
        .HRESETN    (HRESETN),
        .i_en       (w_tck_en),
        .o_tck      (TCK),
        .o_fall_stb (w_fall),
        .o_rise_stb (w_rise)
    );

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Rejected commands skip the TAP reset preamble and finish after a single cycle in RUN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (w_bad || (w_cmd_op == OP_RESET) || r_synced) w_next = ST_RUN;
                    else                                             w_next = ST_PRE_RST;
                end
            end
            ST_PRE_RST: if (w_fall && (r_tick == TW'(RST_TICKS - 1))) w_next = ST_RUN;
            ST_RUN:     if (r_tick == r_total) w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == ST_IDLE);
        busy      = (r_state != ST_IDLE);
        rsp_valid = (r_state == ST_DONE);
        w_tck_en  = (r_state == ST_PRE_RST) || ((r_state == ST_RUN) && (r_tick != r_total));
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_op      <= OP_RESET;
            r_len     <= '0;
            r_total   <= '0;
            r_tick    <= '0;
            r_err     <= 1'b0;
            r_synced  <= 1'b0;
            r_sr      <= '0;
            r_cap     <= '0;
            r_tms     <= 1'b1;
            r_tdi     <= 1'b0;
            r_trstb   <= 1'b0;
            r_rsp_tdo <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_trstb <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= w_cmd_op;
                        r_len   <= cmd_len;
                        r_total <= w_cmd_total;
                        r_err   <= w_bad;
                        r_sr    <= cmd_tdi;
                        r_cap   <= '0;
                        r_tick  <= '0;
                        r_tdi   <= 1'b0;
                        if (!w_bad)
                            r_tms <= (w_next == ST_PRE_RST) ? TMS_RST[0] : tms_for(w_cmd_op, TW'(0), cmd_len);
                    end
                end
                ST_PRE_RST: begin
                    if (w_fall) begin
                        if (r_tick == TW'(RST_TICKS - 1)) begin
                            r_tick   <= '0;
                            r_synced <= 1'b1;
                            r_tms    <= tms_for(r_op, TW'(0), r_len);
                        end else begin
                            r_tick <= w_tick_inc;
                            r_tms  <= TMS_RST[w_tick_inc[2:0]];
                        end
                    end
                end
                ST_RUN: begin
                    if (w_rise && shift_for(r_op, r_tick, r_len))
                        r_cap <= {TDO, r_cap[MAX_LEN-1:1]};
                    if (w_fall) begin
                        r_tick <= w_tick_inc;
                        r_tdi  <= 1'b0;
                        if (w_tick_inc != r_total) begin
                            r_tms <= tms_for(r_op, w_tick_inc, r_len);
                            if (shift_for(r_op, w_tick_inc, r_len)) begin
                                r_tdi <= r_sr[0];
                                r_sr  <= r_sr >> 1;
                            end
                        end
                    end
                    // Captured bits sit at the top of r_cap; realign so the first bit lands in [0].
                    if (r_tick == r_total) begin
                        r_rsp_tdo <= r_err ? '0 : (r_cap >> w_rsh);
                        r_rsp_err <= r_err;
                        if (r_op == OP_RESET) r_synced <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign TMS     = r_tms;
    assign TDI     = r_tdi;
    assign TRSTB   = r_trstb;
    assign rsp_tdo = r_rsp_tdo;
    assign rsp_err = r_rsp_err;

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// Bench for jtag_tap_sequencer: behavioural TAP model on the pins, scoreboard of expected responses.
module tb_jtag_tap_sequencer;
    import jtag_seq_pkg::*;

    localparam int MAX_LEN = 32;
    localparam logic [31:0] IDCODE = 32'h1E0010CF;
    localparam logic [31:0] DTMCS  = 32'h00005071;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_tdi;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_tdo;
    logic        TCK, TMS, TDI, TRSTB;
    logic        m_tdo = 1'b0;

    int n_vec = 0, n_bad = 0, cyc = 0;
    int tck_rises = 0, tms_hi = 0;

    typedef struct {
        logic [31:0] tdo;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    jtag_tap_sequencer #(.MAX_LEN(MAX_LEN), .CLK_DIV(2)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_tdi(cmd_tdi),
        .rsp_valid(rsp_valid), .rsp_tdo(rsp_tdo), .rsp_err(rsp_err), .busy(busy),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TRSTB(TRSTB), .TDO(m_tdo)
    );

    // ---------------- behavioural TAP model ----------------
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_e;
    tap_e        ts = TLR;
    logic [4:0]  m_ir = 5'h01, m_ir_sr = 5'h0;
    logic [31:0] m_dr_sr = 32'h0;
    logic        force_shdr = 1'b0;
    bit          tdi_q[$];

    function automatic tap_e tap_next(input tap_e s, input logic tms);
        case (s)
            TLR:   return tms ? TLR   : RTI;
            RTI:   return tms ? SELDR : RTI;
            SELDR: return tms ? SELIR : CAPDR;
            CAPDR: return tms ? EX1DR : SHDR;
            SHDR:  return tms ? EX1DR : SHDR;
            EX1DR: return tms ? UPDR  : PDR;
            PDR:   return tms ? EX2DR : PDR;
            EX2DR: return tms ? UPDR  : SHDR;
            UPDR:  return tms ? SELDR : RTI;
            SELIR: return tms ? TLR   : CAPIR;
            CAPIR: return tms ? EX1IR : SHIR;
            SHIR:  return tms ? EX1IR : SHIR;
            EX1IR: return tms ? UPIR  : PIR;
            PIR:   return tms ? EX2IR : PIR;
            EX2IR: return tms ? UPIR  : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge TCK or negedge TRSTB or posedge force_shdr) begin
        if (!TRSTB) begin
            ts   <= TLR;
            m_ir <= 5'h01;
        end else if (force_shdr) begin
            ts <= SHDR;
        end else begin
            case (ts)
                TLR:   m_ir <= 5'h01;
                CAPDR: m_dr_sr <= (m_ir == 5'h11) ? DTMCS : (m_ir == 5'h01) ? IDCODE : 32'h0;
                SHDR:  begin m_dr_sr <= {TDI, m_dr_sr[31:1]}; tdi_q.push_back(TDI); end
                CAPIR: m_ir_sr <= 5'h01;
                SHIR:  m_ir_sr <= {TDI, m_ir_sr[4:1]};
                UPIR:  m_ir <= m_ir_sr;
                default: ;
            endcase
            ts <= tap_next(ts, TMS);
        end
    end

    always @(negedge TCK or negedge TRSTB) begin
        if (!TRSTB)          m_tdo <= 1'b0;
        else if (ts == SHDR) m_tdo <= m_dr_sr[0];
        else if (ts == SHIR) m_tdo <= m_ir_sr[0];
        else                 m_tdo <= 1'b0;
    end

    always @(posedge TCK) begin
        tck_rises <= tck_rises + 1;
        if (TMS) tms_hi <= tms_hi + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (HRESETN === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, expected no response", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_tdo", 64'(rsp_tdo), 64'(mon_e.tdo));
                check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                check("rsp_latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end
    end

    task automatic send(input logic [1:0] op, input int len, input logic [31:0] tdi,
                        input logic [31:0] etdo, input logic eerr, input int elat,
                        input bit keep, output int acc);
        int n;
        @(negedge HCLK);
        cmd_op    = op;
        cmd_len   = 6'(len);
        cmd_tdi   = tdi;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge HCLK);
            n++;
        end
        if (!cmd_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, expected 1", n);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge HCLK);
        #1;
        acc = cyc;
        exp_q.push_back('{etdo, eerr, acc, elat});
        check("busy_after_accept", 64'(busy), 64'(1));
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge HCLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge HCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int acc1, acc2, q0, r0, t0;
        logic [7:0] seen;
        HRESETN = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = '0; cmd_tdi = '0;
        repeat (3) @(negedge HCLK);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_tck",       64'(TCK),       64'(0));
        check("rst_tms",       64'(TMS),       64'(1));
        check("rst_tdi",       64'(TDI),       64'(0));
        check("rst_trstb",     64'(TRSTB),     64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_err",   64'(rsp_err),   64'(0));
        check("rst_rsp_tdo",   64'(rsp_tdo),   64'(0));
        HRESETN = 1'b1;
        @(negedge HCLK);
        check("trstb_released", 64'(TRSTB), 64'(1));

        // DR scan straight after reset: 6-tick preamble + 13 ticks, IDCODE low byte comes back
        q0 = tdi_q.size();
        send(OP_DR, 8, 32'hA5, 32'hCF, 1'b0, 77, 1'b0, acc1);
        wait_done();
        check("tdi_count", 64'(tdi_q.size() - q0), 64'(8));
        seen = '0;
        if (tdi_q.size() >= q0 + 8)
            for (int i = 0; i < 8; i++) seen[i] = tdi_q[q0 + i];
        check("tdi_bits", 64'(seen), 64'(8'hA5));

        send(OP_IR, 5, 32'h11, 32'h01, 1'b0, 45, 1'b0, acc1);
        wait_done();
        check("model_ir", 64'(m_ir), 64'(5'h11));
        send(OP_DR, 32, 32'h0, DTMCS, 1'b0, 149, 1'b0, acc1);
        wait_done();

        // Rejected lengths: no TCK activity, error response one cycle later
        r0 = tck_rises;
        send(OP_DR, 0, 32'hFFFF, 32'h0, 1'b1, 1, 1'b0, acc1);
        wait_done();
        send(OP_DR, MAX_LEN + 1, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0, acc1);
        wait_done();
        check("tck_static_on_err", 64'(tck_rises - r0), 64'(0));

        @(negedge HCLK);
        force_shdr = 1'b1;
        #1 force_shdr = 1'b0;
        check("model_in_shdr", 64'(ts), 64'(SHDR));
        send(OP_RESET, 0, 32'h0, 32'h0, 1'b0, 25, 1'b0, acc1);
        wait_done();
        check("model_rti_after_reset", 64'(ts), 64'(RTI));

        // Abort an IR scan with HRESETN
        send(OP_IR, 5, 32'h11, 32'h0, 1'b0, 45, 1'b0, acc1);
        repeat (10) @(negedge HCLK);
        #2 HRESETN = 1'b0;
        #1;
        check("abort_tck",       64'(TCK),       64'(0));
        check("abort_tms",       64'(TMS),       64'(1));
        check("abort_tdi",       64'(TDI),       64'(0));
        check("abort_trstb",     64'(TRSTB),     64'(0));
        check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        exp_q.delete();
        repeat (2) @(negedge HCLK);
        HRESETN = 1'b1;
        send(OP_DR, 32, 32'h0, IDCODE, 1'b0, 173, 1'b0, acc1);
        wait_done();

        // Back-to-back idle cycles with cmd_valid held
        r0 = tck_rises;
        t0 = tms_hi;
        send(OP_IDLE, 3, 32'h0, 32'h0, 1'b0, 13, 1'b1, acc1);
        send(OP_IDLE, 3, 32'h0, 32'h0, 1'b0, 13, 1'b0, acc2);
        wait_done();
        check("b2b_accept_gap", 64'(acc2 - acc1), 64'(15));
        check("b2b_tck_rises",  64'(tck_rises - r0), 64'(6));
        check("b2b_tms_high",   64'(tms_hi - t0), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
